// File: rtl/stage_2_pipe.sv
// Registered stage-2 Q15 range update with one-round renormalization and valid/ready handshake.
// Optional STAGE2_STATS_EN adds saturating symbol and shift counters.
module stage_2_pipe #(
  parameter int RANGE_WIDTH  = 16,
  parameter int D_SIZE       = 5,
  parameter int SYMBOL_WIDTH = 4,
  parameter int BOOL_PROB    = 16384
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RANGE_WIDTH-1:0]  UU,
  input  logic [RANGE_WIDTH-1:0]  VV,
  input  logic [RANGE_WIDTH-1:0]  lut_u,
  input  logic [RANGE_WIDTH-1:0]  lut_v,
  input  logic                    COMP_mux_1,
  input  logic [SYMBOL_WIDTH-1:0] symbol,
  input  logic                    bool_flag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RANGE_WIDTH:0]    u,
  output logic [RANGE_WIDTH:0]    v_bool,
  output logic [RANGE_WIDTH-1:0]  initial_range,
  output logic [RANGE_WIDTH-1:0]  out_range,
  output logic [D_SIZE-1:0]       out_d,
  output logic [1:0]              bool_symbol,
  output logic                    COMP_mux_1_out,
  output logic                    err
`ifdef STAGE2_STATS_EN
  ,
  output logic [31:0]             sym_count,
  output logic [31:0]             shift_total
`endif
);

  localparam int RW = RANGE_WIDTH;
  localparam int PW = 2 * RANGE_WIDTH;
  localparam logic [RW-1:0] R_INIT = RW'(1) << (RW - 1);
  localparam logic [RW-1:0] BOOL_P = RW'(BOOL_PROB >> 6);

  logic [RW-1:0]     r_q;
  logic [RW-1:0]     rr;
  logic [RW:0]       u_full;
  logic [RW:0]       v_full;
  logic [RW:0]       vb_full;
  logic [RW-1:0]     range_cdf;
  logic [RW-1:0]     range_bool;
  logic [RW-1:0]     raw;
  logic              raw_zero;
  logic [D_SIZE-1:0] d_val;
  logic [RW-1:0]     norm;
  logic              accept;
  logic              sym_unused;

  assign sym_unused = ^symbol[SYMBOL_WIDTH-1:1];

  function automatic logic [D_SIZE-1:0] lzc(input logic [RW-1:0] x);
    logic found;
    found = 1'b0;
    lzc   = '0;
    for (int i = RW - 1; i >= 0; i--) begin
      if (!found) begin
        if (x[i]) found = 1'b1;
        else      lzc   = lzc + D_SIZE'(1);
      end
    end
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    rr         = r_q >> 8;
    u_full     = (RW+1)'((PW'(rr) * PW'(UU)) >> 1) + (RW+1)'(lut_u);
    v_full     = (RW+1)'((PW'(rr) * PW'(VV)) >> 1) + (RW+1)'(lut_v);
    vb_full    = (RW+1)'((PW'(rr) * PW'(BOOL_P)) >> 1) + (RW+1)'(4);
    range_cdf  = COMP_mux_1 ? (u_full[RW-1:0] - v_full[RW-1:0]) : (r_q - v_full[RW-1:0]);
    range_bool = symbol[0] ? vb_full[RW-1:0] : (r_q - vb_full[RW-1:0]);
    raw        = bool_flag ? range_bool : range_cdf;
    raw_zero   = (raw == '0);
    d_val      = raw_zero ? '0 : lzc(raw);
    norm       = raw << d_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q            <= R_INIT;
      out_valid      <= 1'b0;
      err            <= 1'b0;
      u              <= '0;
      v_bool         <= '0;
      initial_range  <= '0;
      out_range      <= '0;
      out_d          <= '0;
      bool_symbol    <= '0;
      COMP_mux_1_out <= 1'b0;
    end else begin
      if (accept) begin
        out_valid      <= 1'b1;
        u              <= u_full;
        v_bool         <= vb_full;
        initial_range  <= r_q;
        out_range      <= norm;
        out_d          <= d_val;
        bool_symbol    <= {bool_flag, symbol[0]};
        COMP_mux_1_out <= COMP_mux_1;
        if (raw_zero) err <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // flush takes priority over the beat's own range update
      if (flush)                     r_q <= R_INIT;
      else if (accept && !raw_zero)  r_q <= norm;
    end
  end

`ifdef STAGE2_STATS_EN
  logic [32:0] st_sum;
  assign st_sum = {1'b0, shift_total} + 33'(d_val);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_count   <= '0;
      shift_total <= '0;
    end else if (flush) begin
      sym_count   <= '0;
      shift_total <= '0;
    end else if (accept) begin
      if (sym_count != 32'hFFFF_FFFF) sym_count <= sym_count + 32'd1;
      shift_total <= st_sum[32] ? 32'hFFFF_FFFF : st_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_stage_2_pipe.sv
// Directed self-checking bench for stage_2_pipe; hand-computed expectations at default parameters.
module tb_stage_2_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] UU, VV, lut_u, lut_v;
  logic        COMP_mux_1;
  logic [3:0]  symbol;
  logic        bool_flag;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] u, v_bool;
  logic [15:0] initial_range, out_range;
  logic [4:0]  out_d;
  logic [1:0]  bool_symbol;
  logic        COMP_mux_1_out;
  logic        err;
`ifdef STAGE2_STATS_EN
  logic [31:0] sym_count, shift_total;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  stage_2_pipe dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .UU(UU), .VV(VV), .lut_u(lut_u), .lut_v(lut_v),
    .COMP_mux_1(COMP_mux_1), .symbol(symbol), .bool_flag(bool_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .u(u), .v_bool(v_bool), .initial_range(initial_range),
    .out_range(out_range), .out_d(out_d), .bool_symbol(bool_symbol),
    .COMP_mux_1_out(COMP_mux_1_out), .err(err)
`ifdef STAGE2_STATS_EN
    , .sym_count(sym_count), .shift_total(shift_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bool(input logic sym);
    in_valid   = 1'b1;
    bool_flag  = 1'b1;
    symbol     = {3'b000, sym};
    COMP_mux_1 = 1'b0;
    UU = '0; VV = '0; lut_u = '0; lut_v = '0;
  endtask

  task automatic drive_cdf(input logic comp, input logic [15:0] uu, input logic [15:0] vv,
                           input logic [15:0] lu, input logic [15:0] lv);
    in_valid   = 1'b1;
    bool_flag  = 1'b0;
    symbol     = 4'd0;
    COMP_mux_1 = comp;
    UU = uu; VV = vv; lut_u = lu; lut_v = lv;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    UU = '0; VV = '0; lut_u = '0; lut_v = '0;
    COMP_mux_1 = 1'b0; symbol = '0; bool_flag = 1'b0;
    #2;
    apply_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_out_range", out_range, 0);
    check("rst_u", u, 0);
    check("rst_in_ready", in_ready, 1);

    // bool symbol 1 from R=0x8000
    drive_bool(1'b1);
    step();
    in_valid = 1'b0;
    check("b1_out_valid", out_valid, 1);
    check("b1_init", initial_range, 16'h8000);
    check("b1_vbool", v_bool, 16388);
    check("b1_range", out_range, 16'h8008);
    check("b1_d", out_d, 1);
    check("b1_bsym", bool_symbol, 2'b11);

    // reset with a pending output discards it
    reset = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_range", out_range, 0);
    step();
    reset = 1'b1;

    drive_bool(1'b0);
    step();
    check("b0_init", initial_range, 16'h8000);
    check("b0_range", out_range, 16'hFFF0);
    check("b0_d", out_d, 2);
    drive_bool(1'b1);
    step();
    in_valid = 1'b0;
    check("b1b_init", initial_range, 16'hFFF0);
    check("b1b_vbool", v_bool, 32644);
    check("b1b_range", out_range, 16'hFF08);
    check("b1b_d", out_d, 1);

    // flush without a beat: R reloads, output register keeps data, valid drains
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid_clr", out_valid, 0);
    check("fl_range_hold", out_range, 16'hFF08);

    drive_cdf(1'b0, 16'd0, 16'd256, 16'd0, 16'd4);
    step();
    in_valid = 1'b0;
    check("cdf_init", initial_range, 16'h8000);
    check("cdf_u", u, 0);
    check("cdf_range", out_range, 16'hFFF0);
    check("cdf_d", out_d, 2);
    check("cdf_bsym", bool_symbol, 2'b00);
    check("cdf_comp", COMP_mux_1_out, 0);

    // backpressure for three cycles
    out_ready = 1'b0;
    drive_bool(1'b1);
    #1;
    check("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", out_valid, 1);
      check("bp_range", out_range, 16'hFFF0);
      check("bp_init", initial_range, 16'h8000);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_q_init", initial_range, 16'hFFF0);
    check("bp_q_vbool", v_bool, 32644);
    check("bp_q_range", out_range, 16'hFF08);

    // zero raw range
    drive_cdf(1'b1, 16'd100, 16'd100, 16'd8, 16'd8);
    step();
    in_valid = 1'b0;
    check("z_valid", out_valid, 1);
    check("z_range", out_range, 0);
    check("z_d", out_d, 0);
    check("z_err", err, 1);
    check("z_u", u, 12758);
    check("z_comp", COMP_mux_1_out, 1);
    drive_bool(1'b1);
    step();
    in_valid = 1'b0;
    check("z_next_init", initial_range, 16'hFF08);
    check("z_next_range", out_range, 16'hFF08);
    check("z_err_sticky", err, 1);

    // flush together with an accept
    drive_bool(1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fa_init", initial_range, 16'hFF08);
    check("fa_range", out_range, 16'hFF08);
    check("fa_d", out_d, 1);
`ifdef STAGE2_STATS_EN
    check("fa_symcnt", sym_count, 0);
    check("fa_shift", shift_total, 0);
`endif
    drive_bool(1'b1);
    step();
    in_valid = 1'b0;
    check("fa_next_init", initial_range, 16'h8000);
    check("fa_next_range", out_range, 16'h8008);
`ifdef STAGE2_STATS_EN
    check("st_symcnt", sym_count, 1);
    check("st_shift", shift_total, 1);
`endif
    step();
    check("drain_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
